// File: rtl/cpu_control_unit.sv
// Instruction sequencer for the lab8 16-bit RISC CPU: fetches into IR, decodes,
// and drives every datapath strobe as a Moore function of state and held IR.
module cpu_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic [15:0] ir,
    input  logic        Z,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic        adr_sel,
    output logic        w_en,
    output logic        s_sel,
    output logic        mem_we,
    output logic [3:0]  alu_op,
    output logic [3:0]  w_adr,
    output logic [3:0]  r_adr,
    output logic [3:0]  s_adr,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state
);

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_FETCH_W = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_MEM_RD  = 3'd4;
    localparam logic [2:0] ST_WB      = 3'd5;
    localparam logic [2:0] ST_HALT    = 3'd7;

    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       illegal_q;
    logic       illegal_d;
    logic [3:0] opcode;
    logic       op_undefined;

    assign opcode       = ir[15:12];
    assign op_undefined = (opcode >= 4'hC) && (opcode <= 4'hE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH:   if (run || step) state_d = ST_FETCH_W;
            ST_FETCH_W: state_d = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (op_undefined) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:    state_d = (opcode == OP_LD) ? ST_MEM_RD : ST_FETCH;
            ST_MEM_RD:  state_d = ST_WB;
            ST_WB:      state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            // Unused code 6 falls back to a clean fetch
            default:    state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        adr_sel = 1'b0;
        w_en    = 1'b0;
        s_sel   = 1'b0;
        mem_we  = 1'b0;
        alu_op  = 4'h0;
        w_adr   = 4'h0;
        r_adr   = 4'h0;
        s_adr   = 4'h0;
        case (state_q)
            ST_FETCH_W: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_DECODE: begin
                w_adr = ir[11:8];
                r_adr = ir[7:4];
                s_adr = ir[3:0];
            end
            ST_EXEC: begin
                w_adr = ir[11:8];
                r_adr = ir[7:4];
                s_adr = ir[3:0];
                if ((opcode >= 4'h1) && (opcode <= 4'h7)) begin
                    alu_op = opcode;
                    w_en   = 1'b1;
                end else begin
                    case (opcode)
                        OP_LD:   adr_sel = 1'b1;
                        OP_ST: begin
                            adr_sel = 1'b1;
                            mem_we  = 1'b1;
                        end
                        OP_JMP:  pc_ld = 1'b1;
                        OP_JZ:   pc_ld = Z;
                        default: ;
                    endcase
                end
            end
            ST_MEM_RD: begin
                adr_sel = 1'b1;
                w_adr   = ir[11:8];
                r_adr   = ir[7:4];
                s_adr   = ir[3:0];
            end
            ST_WB: begin
                // alu_op 0 passes the S-mux (RAM data) through to the write port
                adr_sel = 1'b1;
                s_sel   = 1'b1;
                w_en    = 1'b1;
                w_adr   = ir[11:8];
                r_adr   = ir[7:4];
                s_adr   = ir[3:0];
            end
            default: ;
        endcase
    end

    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule
